// File: rtl/three_bit_counter_pkg.sv
// Shared constants and types for the three_bit_counter block.
// Optional saturation mode is selected with the THREE_BIT_COUNTER_SAT_EN macro.
package three_bit_counter_pkg;

    localparam int CNT_WIDTH_DEFAULT = 3;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef logic [CNT_WIDTH_DEFAULT-1:0] cnt_t;

endpackage : three_bit_counter_pkg

// File: rtl/three_bit_counter_next.sv
// Combinational next-count and terminal-count calculator for three_bit_counter.
// THREE_BIT_COUNTER_SAT_EN defined: pin at the limits; undefined: modulo wrap.
module three_bit_counter_next
    import three_bit_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    output logic [WIDTH-1:0] count_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             at_limit;
    logic [WIDTH-1:0] stepped;

    // NOTE: combinational logic uses blocking '=' and assigns every output
    // before any branch, so no path can leave a value held (no latch).
    always_comb begin
        at_limit   = (up_down == DIR_UP) ? (count == CNT_MAX) : (count == '0);
        stepped    = (up_down == DIR_UP) ? (count + CNT_ONE) : (count - CNT_ONE);
        tc         = at_limit;
        count_next = stepped;
`ifdef THREE_BIT_COUNTER_SAT_EN
        if (at_limit) begin
            count_next = count;
        end
`endif
    end

endmodule : three_bit_counter_next

// File: rtl/three_bit_counter.sv
// Up/down WIDTH-bit counter with terminal-count flag and async active-high reset.
// Saturating behaviour is enabled by defining THREE_BIT_COUNTER_SAT_EN.
module three_bit_counter
    import three_bit_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Initialiser gives a defined value in simulation before the first reset.
    logic [WIDTH-1:0] count_q = '0;
    logic [WIDTH-1:0] count_d;

    three_bit_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count     (count_q),
        .up_down   (up_down),
        .count_next(count_d),
        .tc        (tc)
    );

    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : three_bit_counter

// File: tb/tb_three_bit_counter.sv
// Directed, table-driven self-checking bench for three_bit_counter (WIDTH=3).
// Expected values follow the build: THREE_BIT_COUNTER_SAT_EN selects the saturating table.
module tb_three_bit_counter;
    import three_bit_counter_pkg::*;

    logic clk;
    logic rst;
    logic up_down;
    cnt_t count;
    logic tc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic ud;
        cnt_t cnt;
        logic tc;
    } vec_t;

    vec_t vecs[$];

    three_bit_counter #(
        .WIDTH(CNT_WIDTH_DEFAULT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .up_down(up_down),
        .count  (count),
        .tc     (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Wrap/saturate table, starting from count=0. Each entry: direction
        // driven before an edge, then count and tc sampled on the falling edge.
`ifdef THREE_BIT_COUNTER_SAT_EN
        vecs.push_back('{1'b1, 3'd1, 1'b0}); vecs.push_back('{1'b1, 3'd2, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 1'b0}); vecs.push_back('{1'b1, 3'd4, 1'b0});
        vecs.push_back('{1'b1, 3'd5, 1'b0}); vecs.push_back('{1'b1, 3'd6, 1'b0});
        vecs.push_back('{1'b1, 3'd7, 1'b1}); vecs.push_back('{1'b1, 3'd7, 1'b1});
        vecs.push_back('{1'b1, 3'd7, 1'b1}); vecs.push_back('{1'b1, 3'd7, 1'b1});
        vecs.push_back('{1'b0, 3'd6, 1'b0}); vecs.push_back('{1'b0, 3'd5, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 1'b0}); vecs.push_back('{1'b0, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 1'b0}); vecs.push_back('{1'b0, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b1}); vecs.push_back('{1'b0, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 1'b1});
`else
        vecs.push_back('{1'b1, 3'd1, 1'b0}); vecs.push_back('{1'b1, 3'd2, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 1'b0}); vecs.push_back('{1'b1, 3'd4, 1'b0});
        vecs.push_back('{1'b1, 3'd5, 1'b0}); vecs.push_back('{1'b1, 3'd6, 1'b0});
        vecs.push_back('{1'b1, 3'd7, 1'b1}); vecs.push_back('{1'b1, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 3'd7, 1'b0}); vecs.push_back('{1'b0, 3'd6, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 1'b0}); vecs.push_back('{1'b0, 3'd4, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 1'b0}); vecs.push_back('{1'b0, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 1'b0}); vecs.push_back('{1'b0, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 3'd7, 1'b0});
`endif

        // Power-up without reset: counting starts from the initial value 0.
        rst     = 1'b0;
        up_down = 1'b1;
        #1;
        check("powerup_count", 32'(count), 32'd0);
        check("powerup_tc", 32'(tc), 32'd0);
        @(negedge clk);
        check("first_edge_count", 32'(count), 32'd1);
        @(negedge clk);
        check("second_edge_count", 32'(count), 32'd2);

        // Direction change takes effect at the very next edge.
        up_down = 1'b0;
        #1;
        check("down_tc_at_2", 32'(tc), 32'd0);
        @(negedge clk);
        check("down_count_1", 32'(count), 32'd1);
        @(negedge clk);
        check("down_count_0", 32'(count), 32'd0);
        check("down_tc_at_0", 32'(tc), 32'd1);

        // Asynchronous reset asserted midway between edges.
        up_down = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_count", 32'(count), 32'd0);
        check("reset_tc_up", 32'(tc), 32'd0);
        up_down = 1'b0;
        #1;
        check("reset_tc_down", 32'(tc), 32'd1);
        up_down = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold_%0d", i), 32'(count), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_count_1", 32'(count), 32'd1);
        @(negedge clk);
        check("post_reset_count_2", 32'(count), 32'd2);

        // Table-driven wrap / saturate sweep from 0.
        pulse_reset();
        check("table_start_count", 32'(count), 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            up_down = vecs[i].ud;
            @(negedge clk);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].tc));
        end

        // Toggle direction every cycle starting from 3: 4, 3, 4, 3.
        pulse_reset();
        up_down = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("toggle_start_count", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) begin
            up_down = (i % 2 == 0) ? DIR_UP : DIR_DOWN;
            @(negedge clk);
            check($sformatf("toggle_%0d_count", i), 32'(count), (i % 2 == 0) ? 32'd4 : 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_three_bit_counter

// File: doc/three_bit_counter.md
# three_bit_counter

Synchronous 3-bit up/down binary counter with asynchronous active-high reset. It provides a small free-running event or sequence counter for control logic. The count direction is selected each cycle by a single input. A terminal-count flag marks the cycle before wrap-around, so cascaded or supervising logic can detect it.

## Interface
- `WIDTH`, default 3: counter width in bits. Legal range 2..16. Default build is 3.
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst`, input, 1: reset. Asynchronous and active-high. Forces `count` to 0 immediately, independent of `clk`.
- `up_down`, input, 1: direction. 1 = increment, 0 = decrement. Sampled on each rising edge of `clk`.
- `count`, output, WIDTH: current counter value, driven directly from a register.
- `tc`, output, 1: terminal count, combinational from `count` and `up_down`.
  - High when `up_down`=1 and `count`=2^WIDTH−1.
  - High when `up_down`=0 and `count`=0.

## Operation
- While `rst`=1, `count`=0 and rising edges of `clk` are ignored.
- On each rising `clk` edge with `rst`=0:
  - `up_down`=1: `count` <= `count`+1, modulo 2^WIDTH.
  - `up_down`=0: `count` <= `count`−1, modulo 2^WIDTH.
- The counter counts on every cycle; there is no hold state.
- Wrap-around in the default build:
  - 7 -> 0 when counting up.
  - 0 -> 7 when counting down.
- Arithmetic is unsigned WIDTH-bit; the carry or borrow is discarded.
- A direction change takes effect at the next rising edge. There is no pipeline and no turnaround cycle.
- Power-up: the `count` register has a simulation initial value of 0, so it is defined before any reset. Hardware relies on `rst` being asserted.
- `tc` reflects the current `up_down` combinationally. It is 0 while `rst` is held, except when `up_down`=0, since `count`=0 then.

## Timing
- `count` reset value: 0. `tc` value during reset: equals `~up_down`.
- Latency: 1 clock from a sampled `up_down` to the updated `count`.
- Reset assertion mid-count: `count` goes to 0 within the same simulation time step, without waiting for `clk`.
- Reset deassertion: the first count update happens on the first rising edge where `rst` is sampled 0. With `rst` falling exactly at a rising edge, that edge counts from 0.
- `up_down` must meet setup/hold relative to the rising edge of `clk`. In a bench, change it away from the edge, e.g. on the falling edge.

## Configuration
- `THREE_BIT_COUNTER_SAT_EN` defined: the counter saturates instead of wrapping.
  - `count` holds at 2^WIDTH−1 when counting up.
  - `count` holds at 0 when counting down.
  - `tc` keeps the same definition: high while pinned at the limit in the current direction.
- Macro undefined (default): modulo wrap-around as described in Operation.

## Structure
- Package `three_bit_counter_pkg` holds:
  - `CNT_WIDTH_DEFAULT = 3`.
  - Direction constants `DIR_DOWN = 1'b0` and `DIR_UP = 1'b1`.
  - Typedef `cnt_t` = `logic [CNT_WIDTH_DEFAULT-1:0]`.
- One sub-module, `three_bit_counter_next`: a purely combinational next-state and terminal-count calculator.
  - Inputs: `count` and `up_down`.
  - Outputs: `count_next` and `tc`.
  - Contains the wrap/saturate selection under the macro.
- The top holds only the asynchronously reset register and the instance.

## Test plan
- No reset, `up_down`=1 from t=0, clock period 10 with first rising edge at t=5 -> `count` = 1 at t=10 and 2 at t=20.
- From `count`=2, set `up_down`=0 before the next edge -> `count` = 1 one cycle later, then 0.
- Assert `rst`=1 midway between clock edges with `count`≠0 -> `count`=0 immediately, stays 0 while held, and counts 1, 2 after release.
- Count up 8 edges from 0 -> 1..7 then 0; `tc`=1 only while `count`=7. Count down from 0 -> 7; `tc`=1 only while `count`=0.
- With `THREE_BIT_COUNTER_SAT_EN` defined: count up 10 edges from 0 -> holds at 7 with `tc`=1. Count down from 0 -> holds at 0.
- Toggle `up_down` every cycle starting at `count`=3 -> `count` alternates 4, 3, 4, 3.
